// File: rtl/koa_mult_stream_if.sv
// Streaming wrapper around a one-level Karatsuba multiplier: gathers two operands from a narrow
// valid/ready bus, multiplies, and returns the registered product as a beat stream.
module koa_mult_stream_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned BUS_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
);

  localparam int unsigned NI    = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned NO    = 2 * NI;
  localparam int unsigned CntW  = $clog2(NO);
  localparam int unsigned HalfW = DATA_WIDTH / 2;
  localparam logic [CntW-1:0] NiLast = CntW'(NI - 1);
  localparam logic [CntW-1:0] NoLast = CntW'(NO - 1);

  typedef enum logic [1:0] {StLoadA, StLoadB, StMult, StSend} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;

  // koa_multiplier core
  logic [DATA_WIDTH-1:0]   mult_a, mult_b;
  logic [2*DATA_WIDTH-1:0] mult_d;
  logic [HalfW-1:0]        a_lo, a_hi, b_lo, b_hi;
  logic [HalfW:0]          sum_a, sum_b;
  logic [DATA_WIDTH-1:0]   z0, z2;
  logic [DATA_WIDTH+1:0]   z_mid, z1;

  assign mult_a = a_q;
  assign mult_b = b_q;

  always_comb begin
    a_lo  = mult_a[HalfW-1:0];
    a_hi  = mult_a[DATA_WIDTH-1:HalfW];
    b_lo  = mult_b[HalfW-1:0];
    b_hi  = mult_b[DATA_WIDTH-1:HalfW];
    sum_a = {1'b0, a_lo} + {1'b0, a_hi};
    sum_b = {1'b0, b_lo} + {1'b0, b_hi};
    z0    = {{HalfW{1'b0}}, a_lo} * {{HalfW{1'b0}}, b_lo};
    z2    = {{HalfW{1'b0}}, a_hi} * {{HalfW{1'b0}}, b_hi};
    z_mid = {{(HalfW + 1){1'b0}}, sum_a} * {{(HalfW + 1){1'b0}}, sum_b};
    // Middle term is a_lo*b_hi + a_hi*b_lo, never negative.
    z1    = z_mid - {2'b00, z0} - {2'b00, z2};
    mult_d = {z2, z0} + {{(HalfW - 2){1'b0}}, z1, {HalfW{1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    unique case (state_q)
      StLoadA: begin
        if (s_valid) begin
          a_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = s_data;
          if (cnt_q == NiLast) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StLoadB: begin
        if (s_valid) begin
          b_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = s_data;
          if (cnt_q == NiLast) begin
            cnt_d   = '0;
            state_d = StMult;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StMult: begin
        prod_d  = mult_d;
        state_d = StSend;
      end
      StSend: begin
        if (m_ready) begin
          if (cnt_q == NoLast) begin
            cnt_d   = '0;
            state_d = StLoadA;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadA;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // Outputs decode only flopped state, so they hold steady under backpressure.
  assign s_ready = (state_q == StLoadA) || (state_q == StLoadB);
  assign m_valid = (state_q == StSend);
  assign m_last  = (state_q == StSend) && (cnt_q == NoLast);
  assign m_data  = prod_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
  assign busy    = !((state_q == StLoadA) && (cnt_q == '0));

endmodule

// File: tb/tb_koa_mult_stream_if.sv
// Scoreboard bench for koa_mult_stream_if: directed operand pairs, expected beats queued at issue,
// a negedge monitor pops and compares every accepted output beat.
module tb_koa_mult_stream_if;

  localparam int DW = 128;
  localparam int BW = 32;
  localparam int NI = DW / BW;
  localparam int NO = 2 * NI;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;

  koa_mult_stream_if #(
    .DATA_WIDTH(DW),
    .BUS_WIDTH (BW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e_mon;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: compare accepted beats and stability while stalled.
  logic          hold_v = 1'b0;
  logic [BW-1:0] hold_data;
  logic          hold_last;
  always @(negedge clk) begin
    if (!rst && hold_v) begin
      chk("stall_m_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_m_data", {32'd0, m_data}, {32'd0, hold_data});
      chk("stall_m_last", {63'd0, m_last}, {63'd0, hold_last});
    end
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {32'd0, m_data}, 64'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("m_data", {32'd0, m_data}, {32'd0, e_mon.data});
        chk("m_last", {63'd0, m_last}, {63'd0, e_mon.last});
      end
    end
    hold_v    <= !rst && m_valid && !m_ready;
    hold_data <= m_data;
    hold_last <= m_last;
  end

  task automatic push_prod(input logic [2*DW-1:0] p);
    for (int k = 0; k < NO; k++) begin
      beat_t e;
      e.data = p[k*BW +: BW];
      e.last = (k == NO - 1);
      exp_q.push_back(e);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [BW-1:0] d, input bit gaps);
    int g;
    int n;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("s_ready_timeout", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_operands(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit gaps);
    for (int i = 0; i < NI; i++) send_word(a[i*BW +: BW], gaps);
    for (int i = 0; i < NI; i++) send_word(b[i*BW +: BW], gaps);
    chk("s_ready_in_mult", {63'd0, s_ready}, 64'd0);
    chk("m_valid_in_mult", {63'd0, m_valid}, 64'd0);
    chk("busy_in_mult", {63'd0, busy}, 64'd1);
  endtask

  task automatic recv_product(input int stall_beat);
    int got;
    int cyc;
    int stall_left;
    got = 0;
    cyc = 0;
    stall_left = 5;
    @(posedge clk);
    #1;
    chk("m_valid_latency", {63'd0, m_valid}, 64'd1);
    while (got < NO && cyc < 200) begin
      bit x;
      if (got == stall_beat && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'b1;
      end
      x = m_valid && m_ready;
      if (got < NO - 1 && !m_ready) chk("s_ready_in_send", {63'd0, s_ready}, 64'd0);
      @(posedge clk);
      #1;
      cyc++;
      if (x) got++;
    end
    if (got < NO) chk("recv_timeout", 64'(got), 64'(NO));
    m_ready = 1'b1;
    chk("s_ready_after_last", {63'd0, s_ready}, 64'd1);
    chk("busy_after_last", {63'd0, busy}, 64'd0);
    chk("m_valid_after_last", {63'd0, m_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ta, tb_op;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_last", {63'd0, m_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_m_data", {32'd0, m_data}, 64'd0);
    rst = 1'b0;

    // 1: zero operands
    push_prod('0);
    send_operands('0, '0, 1'b0);
    recv_product(-1);

    // 2: all ones squared
    push_prod({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001});
    send_operands({DW{1'b1}}, {DW{1'b1}}, 1'b0);
    recv_product(-1);

    // 3: mixed operands with input gaps, expected from a plain wide multiply
    ta    = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
    tb_op = 128'h01234567_89ABCDEF_DEADBEEF_CAFEBABE;
    push_prod({128'd0, ta} * {128'd0, tb_op});
    send_operands(ta, tb_op, 1'b1);
    recv_product(-1);

    // 4: stall 5 cycles at output beat 3
    push_prod({128'd0, ta} * {128'd0, tb_op});
    send_operands(ta, tb_op, 1'b0);
    recv_product(3);

    // 5: reset mid-load with s_valid held, then a fresh 1*5
    for (int i = 0; i < 6; i++) send_word(32'h1111_0000 + 32'(i), 1'b0);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midrst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midrst_m_data", {32'd0, m_data}, 64'd0);
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    push_prod(256'd5);
    send_operands(128'd1, 128'd5, 1'b0);
    recv_product(-1);

    // 6: three back-to-back products
    push_prod(256'd21);
    send_operands(128'd3, 128'd7, 1'b0);
    recv_product(-1);
    push_prod({127'd0, 1'b1, 128'd0});
    send_operands({64'd1, 64'd0}, {64'd1, 64'd0}, 1'b0);
    recv_product(-1);
    push_prod({192'd0, 64'hFFFF_FFFE_0000_0001});
    send_operands(128'hFFFF_FFFF, 128'hFFFF_FFFF, 1'b0);
    recv_product(-1);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
